// File: rtl/spike_pattern_decoder_if.sv
// Result bus from the spike pattern decoder: decoded pattern, winning neuron,
// latched per-neuron counts, and the valid/ready handshake.
interface spike_pattern_decoder_if #(
    parameter int N     = 7,
    parameter int P     = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = 3
);
    logic [P-1:0]       pattern_out;
    logic [IDX_W-1:0]   winner;
    logic [N*CNT_W-1:0] spike_counts;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output pattern_out,
        output winner,
        output spike_counts,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  pattern_out,
        input  winner,
        input  spike_counts,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/spike_pattern_decoder.sv
// Readout for the Hopfield spiking core: counts spike rising edges per neuron
// over a fixed window, thresholds them into a pattern and reports the busiest neuron.
module spike_pattern_decoder #(
    parameter int N      = 7,
    parameter int P      = 4,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N-1:0]         spikes,
    input  logic [CNT_W-1:0]     thresh,
    spike_pattern_decoder_if.master res
);
    localparam int                WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, COUNT, EVAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [N-1:0]       spikes_q;
    logic [N-1:0]       rise;
    logic [CNT_W-1:0]   cnt_q   [N];
    logic [CNT_W-1:0]   latch_q [N];
    logic [P-1:0]       pattern_q, pattern_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic               valid_q;
    logic               handshake;
    logic               start;
    logic [CNT_W-1:0]   best_val;

    assign rise      = spikes & ~spikes_q;
    assign handshake = valid_q & res.out_ready;
    // Counters are cleared on every entry into COUNT, whichever state we came from.
    assign start     = (state_d == COUNT) && (state_q != COUNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable) state_d = COUNT;
            COUNT: begin
                if (!enable)                    state_d = IDLE;
                else if (win_cnt_q == WIN_LAST) state_d = EVAL;
            end
            EVAL:  state_d = DONE;
            DONE:  if (handshake) state_d = enable ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties and yields 0 when all counts are zero.
    always_comb begin
        winner_d = '0;
        best_val = cnt_q[0];
        for (int k = 1; k < N; k++) begin
            if (cnt_q[k] > best_val) begin
                best_val = cnt_q[k];
                winner_d = IDX_W'(k);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_pat
            assign pattern_d[gi] = (cnt_q[gi] >= thresh);
        end
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign res.spike_counts[gi*CNT_W +: CNT_W] = latch_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            spikes_q  <= '0;
            pattern_q <= '0;
            winner_q  <= '0;
            valid_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k]   <= '0;
                latch_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            spikes_q  <= spikes;
            win_cnt_q <= (state_q == COUNT) ? win_cnt_q + WIN_W'(1) : '0;
            for (int k = 0; k < N; k++) begin
                if (start)
                    cnt_q[k] <= '0;
                else if (state_q == COUNT && rise[k] && cnt_q[k] != CNT_MAX)
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
            if (state_q == EVAL) begin
                for (int k = 0; k < N; k++) latch_q[k] <= cnt_q[k];
                pattern_q <= pattern_d;
                winner_q  <= winner_d;
                valid_q   <= 1'b1;
            end else if (handshake) begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign res.pattern_out = pattern_q;
    assign res.winner      = winner_q;
    assign res.out_valid   = valid_q;
endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Scoreboard bench for spike_pattern_decoder: directed windows push expected
// results, monitors compare them when out_valid rises.
module tb_spike_pattern_decoder;
    localparam int N = 7, P = 4, CNT_W = 8, IDX_W = 3, WIN = 16;
    localparam int CW_S = 3, WIN_S = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             enable;
    logic [N-1:0]     spikes;
    logic [CNT_W-1:0] thresh;
    logic             en_s;
    logic [N-1:0]     spk_s;
    logic [CW_S-1:0]  thr_s;

    spike_pattern_decoder_if #(.N(N), .P(P), .CNT_W(CNT_W), .IDX_W(IDX_W)) res_if ();
    spike_pattern_decoder_if #(.N(N), .P(P), .CNT_W(CW_S),  .IDX_W(IDX_W)) res_s_if ();

    spike_pattern_decoder #(.N(N), .P(P), .WINDOW(WIN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spikes(spikes), .thresh(thresh), .res(res_if)
    );
    spike_pattern_decoder #(.N(N), .P(P), .WINDOW(WIN_S), .CNT_W(CW_S), .IDX_W(IDX_W)) dut_s (
        .clk(clk), .reset(reset), .enable(en_s), .spikes(spk_s), .thresh(thr_s), .res(res_s_if)
    );

    typedef struct {
        logic [P-1:0]     pat;
        logic [IDX_W-1:0] win;
        logic [63:0]      cnt;
        int               at_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t sb_s[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event occurred that no expectation allows", name);
    endtask

    logic v_prev  = 1'b0;
    logic vs_prev = 1'b0;

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (res_if.out_valid && !v_prev) begin
            if (sb.size() == 0) flag("unexpected_valid");
            else begin
                e = sb.pop_front();
                check("pattern_out", 64'(res_if.pattern_out), 64'(e.pat));
                check("winner", 64'(res_if.winner), 64'(e.win));
                check("spike_counts", 64'(res_if.spike_counts), e.cnt);
                if (e.at_cyc >= 0) check("valid_latency", 64'(cyc), 64'(e.at_cyc));
                $display("result: pattern=%b winner=%0d counts=%h", res_if.pattern_out,
                         res_if.winner, res_if.spike_counts);
            end
        end
        v_prev = res_if.out_valid;
    end

    always @(negedge clk) begin : mon_sat
        exp_t e;
        if (res_s_if.out_valid && !vs_prev) begin
            if (sb_s.size() == 0) flag("unexpected_valid_sat");
            else begin
                e = sb_s.pop_front();
                check("sat_pattern_out", 64'(res_s_if.pattern_out), 64'(e.pat));
                check("sat_winner", 64'(res_s_if.winner), 64'(e.win));
                check("sat_spike_counts", 64'(res_s_if.spike_counts), e.cnt);
                $display("sat result: pattern=%b winner=%0d counts=%h", res_s_if.pattern_out,
                         res_s_if.winner, res_s_if.spike_counts);
            end
        end
        vs_prev = res_s_if.out_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Neuron k pulses on even cycles of the window, pulses[k] times; hold bits stay high.
    task automatic run_window(input int pulses [N], input logic [N-1:0] hold,
                              input logic [P-1:0] e_pat, input logic [IDX_W-1:0] e_win,
                              input logic [63:0] e_cnt, input bit lat, input int abort_at);
        exp_t e;
        logic [N-1:0] s;
        enable = 1'b1;
        for (int j = 0; j < WIN; j++) begin
            @(negedge clk);
            if (j == 0 && abort_at < 0) begin
                e.pat = e_pat; e.win = e_win; e.cnt = e_cnt;
                e.at_cyc = lat ? cyc + WIN + 1 : -1;
                sb.push_back(e);
            end
            s = hold;
            for (int k = 0; k < N; k++)
                if ((j % 2) == 0 && (j / 2) < pulses[k]) s[k] = 1'b1;
            spikes = s;
            if (j == abort_at) begin
                enable = 1'b0;
                spikes = hold;
                return;
            end
        end
        @(negedge clk);
        enable = 1'b0;
        spikes = hold;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!res_if.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!res_if.out_valid) flag("valid_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] CNT_T4 = 64'h0000_0006_0600_0000;

    initial begin
        int vcount;
        exp_t es;
        reset = 1'b1; enable = 1'b0; spikes = 7'h7F; thresh = 8'd3;
        en_s = 1'b0; spk_s = '0; thr_s = 3'd3;
        res_if.out_ready = 1'b1; res_s_if.out_ready = 1'b1;
        idle(3);
        check("rst_valid", 64'(res_if.out_valid), 64'h0);
        check("rst_pattern", 64'(res_if.pattern_out), 64'h0);
        check("rst_winner", 64'(res_if.winner), 64'h0);
        check("rst_counts", 64'(res_if.spike_counts), 64'h0);
        reset = 1'b0;

        // Spikes already high across reset release: no rising edge, nothing counted.
        run_window('{0, 0, 0, 0, 0, 0, 0}, 7'h7F, 4'b0000, 3'd0, 64'h0, 1'b1, -1);
        idle(25); spikes = '0; idle(3);

        run_window('{5, 0, 3, 0, 0, 7, 0}, 7'h00, 4'b0101, 3'd5, 64'h0000_0700_0003_0005, 1'b1, -1);
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (res_if.out_valid) vcount++;
        end
        check("valid_pulse_width", 64'(vcount), 64'd1);

        // Neuron 1 held high across two windows: counts once, then not again.
        run_window('{0, 0, 0, 0, 0, 0, 0}, 7'h02, 4'b0000, 3'd1, 64'h0000_0000_0000_0100, 1'b1, -1);
        idle(25);
        run_window('{0, 0, 0, 0, 0, 0, 0}, 7'h02, 4'b0000, 3'd0, 64'h0, 1'b1, -1);
        idle(25); spikes = '0; idle(2);

        // Tie between neurons 3 and 4 under backpressure.
        res_if.out_ready = 1'b0;
        run_window('{0, 0, 0, 6, 6, 0, 0}, 7'h00, 4'b1000, 3'd3, CNT_T4, 1'b1, -1);
        wait_valid();
        repeat (10) begin
            @(negedge clk);
            spikes[0] = ~spikes[0];
            check("stall_valid", 64'(res_if.out_valid), 64'h1);
            check("stall_outputs", 64'({res_if.pattern_out, res_if.winner, res_if.spike_counts}),
                  64'({4'b1000, 3'd3, CNT_T4[55:0]}));
        end
        spikes = '0;
        res_if.out_ready = 1'b1;
        @(negedge clk);
        check("valid_after_accept", 64'(res_if.out_valid), 64'h0);
        idle(3);

        // Abort at win_cnt 8: no result, previous outputs retained.
        run_window('{2, 2, 2, 2, 2, 2, 2}, 7'h00, 4'b0000, 3'd0, 64'h0, 1'b0, 8);
        vcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (res_if.out_valid) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'h0);
        check("abort_outputs_held", 64'({res_if.pattern_out, res_if.winner, res_if.spike_counts}),
              64'({4'b1000, 3'd3, CNT_T4[55:0]}));

        // Reset asserted while a result waits in DONE.
        res_if.out_ready = 1'b0;
        run_window('{5, 0, 0, 0, 0, 0, 0}, 7'h00, 4'b0001, 3'd0, 64'h5, 1'b1, -1);
        wait_valid();
        idle(2);
        #2 reset = 1'b1;
        #1;
        check("rst_done_valid", 64'(res_if.out_valid), 64'h0);
        check("rst_done_pattern", 64'(res_if.pattern_out), 64'h0);
        check("rst_done_winner", 64'(res_if.winner), 64'h0);
        check("rst_done_counts", 64'(res_if.spike_counts), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        res_if.out_ready = 1'b1;
        idle(2);

        // Saturation: neuron 6 rises 16 times in a 32-cycle window with 3-bit counters.
        en_s = 1'b1;
        es.pat = 4'b0000; es.win = 3'd6; es.cnt = 64'h1C_0000; es.at_cyc = -1;
        sb_s.push_back(es);
        for (int j = 0; j < WIN_S; j++) begin
            @(negedge clk);
            spk_s = ((j % 2) == 0) ? 7'h40 : 7'h00;
        end
        @(negedge clk);
        en_s = 1'b0;
        spk_s = '0;
        idle(10);

        check("sb_empty", 64'(sb.size()), 64'h0);
        check("sb_sat_empty", 64'(sb_s.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/spike_pattern_decoder.md
Name: spike_pattern_decoder

Overview:
- Readout side of the Hopfield spiking core: converts the N neuron spike trains back into a recalled binary pattern.
- Counts spike rising edges per neuron over a fixed window and thresholds the first P counts into pattern bits.
- Reports the most active neuron.
- Presents results with a valid/ready handshake to downstream logic (host interface / learning supervisor).

Parameters:
- N, 7, number of neurons / spike inputs
- P, 4, number of decoded pattern bits (neurons 0..P-1), P <= N
- WINDOW, 1024, counting window length in clk cycles (>= 2)
- CNT_W, 8, per-neuron spike counter width
- IDX_W, 3, width of winner index (>= clog2(N))

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  level; high = run back-to-back windows, low = stop after current handshake / abort counting
- spikes  input  N  spike outputs of neuron array, bit k = neuron k
- thresh  input  CNT_W  unsigned rate threshold, sampled in EVAL
- pattern_out  output  P  bit k = (count[k] >= thresh)
- winner  output  IDX_W  index of neuron with largest count
- spike_counts  output  N*CNT_W  latched counts, neuron k at bits [k*CNT_W +: CNT_W]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Reset: state=IDLE; all counters, spikes_d, pattern_out, winner, spike_counts, and out_valid = 0.
- Edge detect: spikes_d <= spikes every cycle in every state.
  - edge[k] = spikes[k] & ~spikes_d[k].
  - A spike held high over many cycles counts once.
  - A spike held across a window boundary is not recounted.
- FSM states: IDLE, COUNT, EVAL, DONE.
- IDLE:
  - enable=1 -> COUNT next cycle.
  - Entry clears win_cnt and all per-neuron counters.
- COUNT:
  - Lasts exactly WINDOW cycles (win_cnt 0..WINDOW-1).
  - Each cycle, count[k] += edge[k]; counters saturate at 2^CNT_W-1, no wrap.
  - At win_cnt==WINDOW-1, that cycle's edges are still counted -> EVAL.
  - enable=0 in any COUNT cycle: abort -> IDLE; counts discarded; outputs unchanged; out_valid stays 0.
- EVAL (one cycle):
  - Register spike_counts from counters.
  - pattern_out[k] = count[k] >= thresh (unsigned).
  - winner = index of max count; ties -> lowest index; all-zero -> 0.
  - Then DONE with out_valid=1 from the next cycle.
  - Latency: out_valid rises 2 clk edges after the last COUNT cycle's edge.
  - EVAL ignores enable.
- DONE:
  - out_valid=1; pattern_out, winner, and spike_counts held stable until handshake.
  - Handshake = out_valid & out_ready on a rising edge.
  - On handshake: out_valid <= 0; enable=1 -> COUNT (counters cleared on entry); enable=0 -> IDLE.
  - Spikes arriving in EVAL/DONE are not counted (spikes_d still tracks).
  - Outputs retain last values after handshake until next EVAL.
- thresh=0 -> all pattern bits 1; thresh > 2^CNT_W-1 is impossible by width.
- Reset mid-operation: immediate return to reset state; any pending result lost.

Test Plan:
- Bench uses WINDOW=16, CNT_W=8, thresh=3.
- Reset with spikes=7'h7F held -> all outputs 0, out_valid=0; after release and enable=1 nothing counts until a rising edge occurs.
- Neuron 0 pulses 5x, neuron 2 pulses 3x, neuron 5 pulses 7x, others silent within one window, out_ready=1 -> spike_counts 5,0,3,0,0,7,0; pattern_out=4'b0101; winner=5; out_valid exactly one cycle, 2 edges after window end.
- Neuron 1 held high for the whole window plus the next window -> count 1 in first window, 0 in second.
- Neurons 3 and 4 both pulse 6x -> winner=3; out_ready=0 for 10 cycles -> outputs stable and out_valid held, then accepted; pulses during the wait are uncounted.
- Neuron 6 toggles every cycle with CNT_W=3 and WINDOW=32 -> count saturates at 7, no wrap.
- enable dropped at win_cnt=8 -> IDLE, no out_valid; async reset asserted during DONE -> out_valid drops immediately, all outputs 0.
